// File: rtl/apb_master_pkg.sv
// apb_master_pkg: shared state encoding, debug-bus and response-status bit positions
package apb_master_pkg;
  typedef enum logic [3:0] {
    IDLE   = 4'b0001,
    SETUP  = 4'b0010,
    ACCESS = 4'b0100,
    RESP   = 4'b1000
  } state_t;
  localparam int TPS_HIT       = 4;
  localparam int TPS_STATE_MSB = 3;
  localparam int TPS_STATE_LSB = 0;
  localparam int RSP_ERR       = 0;
  localparam int RSP_TIMEOUT   = 1;
  localparam int RSP_STATUS_W  = 2;
endpackage

// File: rtl/apb_timeout_ctr.sv
// apb_timeout_ctr: counts wait-state cycles and flags the last allowed one
module apb_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic hit
);
  localparam int W = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  end
  assign hit = (TIMEOUT_CYCLES != 0) && (cnt == W'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/apb_master.sv
// apb_master: single-outstanding APB initiator with valid/ready command and response
module apb_master
  import apb_master_pkg::*;
#(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              PCLK,
  input  logic              PRESETN,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR,
  output logic [4:0]        TPS
);
  state_t state, state_nx;
  logic hit;
  logic [RSP_STATUS_W-1:0] rsp_status;
  wire accept = (state == IDLE) && cmd_valid;
  wire finish = (state == ACCESS) && (PREADY || hit);
  apb_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_ctr (
    .clk(PCLK),
    .rst(!PRESETN),
    .clr(accept),
    .en ((state == ACCESS) && !PREADY),
    .hit(hit)
  );
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = cmd_valid ? SETUP : IDLE;
      SETUP:   state_nx = ACCESS;
      ACCESS:  state_nx = (PREADY || hit) ? RESP : ACCESS;
      RESP:    state_nx = rsp_ready ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge PCLK) begin
    if (!PRESETN) state <= IDLE;
    else state <= state_nx;
  end
  // APB and response outputs are registered from the next state so they align with it
  always_ff @(posedge PCLK) begin
    if (!PRESETN) begin
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_status <= '0;
    end else begin
      PSEL      <= (state_nx == SETUP) || (state_nx == ACCESS);
      PENABLE   <= state_nx == ACCESS;
      rsp_valid <= state_nx == RESP;
      if (accept) begin
        PWRITE <= cmd_write;
        PADDR  <= cmd_addr;
        PWDATA <= cmd_write ? cmd_wdata : '0;
      end
      if (finish) begin
        rsp_rdata               <= (PREADY && !PWRITE) ? PRDATA : '0;
        rsp_status[RSP_ERR]     <= !PREADY || PSLVERR;
        rsp_status[RSP_TIMEOUT] <= !PREADY;
      end
    end
  end
  assign cmd_ready   = state == IDLE;
  assign rsp_err     = rsp_status[RSP_ERR];
  assign rsp_timeout = rsp_status[RSP_TIMEOUT];
  assign TPS[TPS_HIT] = hit && (state == ACCESS);
  assign TPS[TPS_STATE_MSB:TPS_STATE_LSB] = state;
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: randomized and directed transfers checked against a transaction-level model
module tb_apb_master;
  localparam int AW = 8, DW = 32, TO = 8;
  logic PCLK = 0, PRESETN = 0;
  logic cmd_valid = 0, cmd_write = 0, rsp_ready = 0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0, PRDATA = '0;
  logic PREADY = 0, PSLVERR = 0;
  logic cmd_ready, rsp_valid, rsp_err, rsp_timeout, PSEL, PENABLE, PWRITE;
  logic [DW-1:0] rsp_rdata, PWDATA;
  logic [AW-1:0] PADDR;
  logic [4:0] TPS;
  int checks = 0, failures = 0;

  apb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .PCLK(PCLK), .PRESETN(PRESETN),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .TPS(TPS)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge PCLK);
    #1;
  endtask

  // One full transfer: the model predicts ACCESS length and response from the slave's wait count
  task automatic xfer(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                      input int waits, input logic err, input logic [DW-1:0] rd, input int hold);
    int acc;
    bit to;
    int exp_acc;
    logic [DW-1:0] exp_rd, exp_wd;
    to      = waits >= TO;
    exp_acc = to ? TO : waits + 1;
    exp_rd  = (wr || to) ? '0 : rd;
    exp_wd  = wr ? wd : '0;
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd;
    step;
    cmd_valid = 0; cmd_addr = AW'($urandom); cmd_wdata = $urandom; cmd_write = $urandom;
    chk("setup_psel", PSEL, 1);
    chk("setup_penable", PENABLE, 0);
    chk("setup_paddr", PADDR, a);
    chk("setup_pwrite", PWRITE, wr);
    chk("setup_pwdata", PWDATA, exp_wd);
    chk("setup_cmd_ready", cmd_ready, 0);
    step;
    acc = 0;
    while (PENABLE && acc < 40) begin
      chk("access_psel", PSEL, 1);
      chk("access_paddr", PADDR, a);
      chk("access_pwrite", PWRITE, wr);
      chk("access_pwdata", PWDATA, exp_wd);
      chk("access_rsp_valid", rsp_valid, 0);
      chk("access_tps_hit", TPS[4], acc == TO - 1);
      PREADY  = acc == waits;
      PSLVERR = err;
      PRDATA  = (acc == waits) ? rd : $urandom;
      acc++;
      step;
    end
    PREADY = 0; PSLVERR = 0;
    chk("access_cycles", acc, exp_acc);
    chk("resp_psel", PSEL, 0);
    chk("resp_penable", PENABLE, 0);
    chk("resp_valid", rsp_valid, 1);
    chk("resp_rdata", rsp_rdata, exp_rd);
    chk("resp_err", rsp_err, to ? 1'b1 : err);
    chk("resp_timeout", rsp_timeout, to);
    repeat (hold) begin
      cmd_valid = $urandom;
      step;
      chk("hold_cmd_ready", cmd_ready, 0);
      chk("hold_psel", PSEL, 0);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_rdata", rsp_rdata, exp_rd);
      chk("hold_err", rsp_err, to ? 1'b1 : err);
      chk("hold_paddr", PADDR, a);
    end
    cmd_valid = 0; rsp_ready = 1;
    step;
    rsp_ready = 0;
    chk("done_rsp_valid", rsp_valid, 0);
    chk("done_cmd_ready", cmd_ready, 1);
    chk("done_psel", PSEL, 0);
  endtask

  initial begin
    step; step;
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_pwrite", PWRITE, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    chk("rst_tps", TPS, 5'b00001);
    chk("rst_cmd_ready", cmd_ready, 1);
    PRESETN = 1;
    step;
    xfer(1, 8'h04, 32'hDEADBEEF, 0, 0, 32'h0, 0);
    xfer(0, 8'h08, 32'h0, 3, 0, 32'h12345678, 0);
    xfer(0, 8'h0C, 32'h0, 0, 1, 32'hCAFEF00D, 0);
    xfer(0, 8'h10, 32'h0, 50, 0, 32'h55AA55AA, 0);
    xfer(1, 8'h14, 32'hA5A5A5A5, 1, 0, 32'h0, 5);
    xfer(0, 8'h18, 32'h0, TO - 1, 0, 32'h0BADCAFE, 0);
    xfer(1, 8'h1C, 32'h11112222, TO, 1, 32'h0, 2);
    for (int i = 0; i < 25; i++)
      xfer($urandom, AW'($urandom), $urandom, $urandom_range(0, TO + 2),
           ($urandom_range(0, 3) == 0), $urandom, $urandom_range(0, 3));
    cmd_valid = 1; cmd_write = 0; cmd_addr = 8'h20;
    step;
    cmd_valid = 0;
    step; step;
    chk("mid_in_access", PENABLE, 1);
    PRESETN = 0;
    step;
    chk("mid_rst_psel", PSEL, 0);
    chk("mid_rst_penable", PENABLE, 0);
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_tps", TPS, 5'b00001);
    PRESETN = 1; PREADY = 1;
    repeat (4) begin
      step;
      chk("post_rst_valid", rsp_valid, 0);
      chk("post_rst_psel", PSEL, 0);
    end
    PREADY = 0;
    xfer(1, 8'h24, 32'h87654321, 2, 0, 32'h0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
